weight_fetch_sched: RTL

WEIGHT_FETCH_SCHED -- requirements
Module: weight_fetch_sched

---
 rtl/weight_fetch_sched.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/weight_fetch_sched.sv
// weight_fetch_sched
// Two-requester weight/bias fetch scheduler. The winner's descriptor is latched,
// one bias word is read from the bias ROM, and the weight words are streamed
// from the weight ROM through a 4-entry output FIFO with ready/valid backpressure.
// Weight reads are throttled so that in-flight reads plus FIFO occupancy never
// exceed the FIFO depth, so no returning ROM word can ever be dropped.
module weight_fetch_sched #(
    parameter int WEIGHT_WIDTH = 8,
    parameter int BIAS_WIDTH   = 16,
    parameter int W_ADDR_WIDTH = 11,
    parameter int B_ADDR_WIDTH = 6,
    parameter int CNT_WIDTH    = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [1:0]                req,
    input  logic [2*W_ADDR_WIDTH-1:0] req_base,
    input  logic [2*CNT_WIDTH-1:0]    req_count,
    input  logic [2*B_ADDR_WIDTH-1:0] req_bias,
    output logic [1:0]                grant,
    output logic [1:0]                done,
    output logic                      busy,
    output logic [W_ADDR_WIDTH-1:0]   rom_waddr,
    input  logic [WEIGHT_WIDTH-1:0]   rom_wdata,
    output logic [B_ADDR_WIDTH-1:0]   rom_baddr,
    input  logic [BIAS_WIDTH-1:0]     rom_bdata,
    output logic                      bias_valid,
    output logic [BIAS_WIDTH-1:0]     bias_out,
    output logic                      w_valid,
    output logic [WEIGHT_WIDTH-1:0]   w_data,
    output logic                      w_last,
    input  logic                      w_ready
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BIAS   = 2'd1,
        STREAM = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    // Advance a FIFO pointer; depth is a power of two so it wraps naturally.
    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return p + 2'd1;
    endfunction

    state_t                    state_r;
    logic                      prio_r;
    logic [1:0]                grant_r;
    logic [1:0]                done_r;
    logic                      busy_r;
    logic [W_ADDR_WIDTH-1:0]   base_r;
    logic [CNT_WIDTH-1:0]      cnt_r;
    logic [CNT_WIDTH-1:0]      rem_iss_r;
    logic [W_ADDR_WIDTH-1:0]   next_addr_r;
    logic [W_ADDR_WIDTH-1:0]   rom_waddr_r;
    logic [B_ADDR_WIDTH-1:0]   rom_baddr_r;
    logic                      bias_cap_r;
    logic                      bias_valid_r;
    logic [BIAS_WIDTH-1:0]     bias_out_r;
    logic                      iss_d1_r;
    logic                      iss_d2_r;
    logic                      iss_last_d1_r;
    logic                      iss_last_d2_r;

    logic [WEIGHT_WIDTH-1:0]   fifo_data_r [4];
    logic                      fifo_last_r [4];
    logic [1:0]                wr_ptr_r;
    logic [1:0]                rd_ptr_r;
    logic [2:0]                occ_r;

    logic                      win_s;
    logic [W_ADDR_WIDTH-1:0]   sel_base_s;
    logic [CNT_WIDTH-1:0]      sel_cnt_s;
    logic [B_ADDR_WIDTH-1:0]   sel_bias_s;
    logic [2:0]                inflight_s;
    logic                      room_s;
    logic                      push_s;
    logic                      pop_s;

    // Round-robin winner: on a tie the priority pointer decides, otherwise the sole requester.
    always_comb begin
        win_s = 1'b0;
        if (req == 2'b11) begin
            win_s = prio_r;
        end else if (req[1]) begin
            win_s = 1'b1;
        end else begin
            win_s = 1'b0;
        end
    end

    assign sel_base_s = win_s ? req_base[2*W_ADDR_WIDTH-1:W_ADDR_WIDTH] : req_base[W_ADDR_WIDTH-1:0];
    assign sel_cnt_s  = win_s ? req_count[2*CNT_WIDTH-1:CNT_WIDTH]      : req_count[CNT_WIDTH-1:0];
    assign sel_bias_s = win_s ? req_bias[2*B_ADDR_WIDTH-1:B_ADDR_WIDTH] : req_bias[B_ADDR_WIDTH-1:0];

    // Reads issued but not yet written into the FIFO, plus what the FIFO already holds.
    assign inflight_s = {2'b00, iss_d1_r} + {2'b00, iss_d2_r};
    assign room_s     = (inflight_s + occ_r) < 3'd4;

    assign push_s = iss_d2_r;
    assign pop_s  = w_valid && w_ready;

    // Main control FSM: arbitration, bias capture, weight read issue and completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= IDLE;
            prio_r        <= 1'b0;
            grant_r       <= 2'b00;
            done_r        <= 2'b00;
            busy_r        <= 1'b0;
            base_r        <= '0;
            cnt_r         <= '0;
            rem_iss_r     <= '0;
            next_addr_r   <= '0;
            rom_waddr_r   <= '0;
            rom_baddr_r   <= '0;
            bias_cap_r    <= 1'b0;
            bias_valid_r  <= 1'b0;
            bias_out_r    <= '0;
            iss_d1_r      <= 1'b0;
            iss_d2_r      <= 1'b0;
            iss_last_d1_r <= 1'b0;
            iss_last_d2_r <= 1'b0;
        end else begin
            done_r        <= 2'b00;
            bias_valid_r  <= 1'b0;
            iss_d1_r      <= 1'b0;
            iss_last_d1_r <= 1'b0;
            iss_d2_r      <= iss_d1_r;
            iss_last_d2_r <= iss_last_d1_r;

            // Bias ROM data returns one cycle after the BIAS state started the read.
            if (bias_cap_r) begin
                bias_out_r   <= rom_bdata;
                bias_valid_r <= 1'b1;
                bias_cap_r   <= 1'b0;
            end

            case (state_r)
                IDLE: begin
                    if (req != 2'b00) begin
                        prio_r      <= ~win_s;
                        grant_r     <= win_s ? 2'b10 : 2'b01;
                        busy_r      <= 1'b1;
                        base_r      <= sel_base_s;
                        cnt_r       <= sel_cnt_s;
                        rom_baddr_r <= sel_bias_s;
                        state_r     <= BIAS;
                    end
                end
                BIAS: begin
                    bias_cap_r <= 1'b1;
                    if (cnt_r == '0) begin
                        state_r <= DRAIN;
                    end else begin
                        // First weight read goes out here; the FIFO is empty so there is room.
                        rom_waddr_r   <= base_r;
                        next_addr_r   <= base_r + W_ADDR_WIDTH'(1);
                        rem_iss_r     <= cnt_r - CNT_WIDTH'(1);
                        iss_d1_r      <= 1'b1;
                        iss_last_d1_r <= (cnt_r == CNT_WIDTH'(1));
                        state_r       <= STREAM;
                    end
                end
                STREAM: begin
                    if (rem_iss_r == '0) begin
                        state_r <= DRAIN;
                    end else if (room_s) begin
                        rom_waddr_r   <= next_addr_r;
                        next_addr_r   <= next_addr_r + W_ADDR_WIDTH'(1);
                        rem_iss_r     <= rem_iss_r - CNT_WIDTH'(1);
                        iss_d1_r      <= 1'b1;
                        iss_last_d1_r <= (rem_iss_r == CNT_WIDTH'(1));
                        if (rem_iss_r == CNT_WIDTH'(1)) begin
                            state_r <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // Zero-count fetches finish once the bias beat has been presented.
                    if (((cnt_r == '0) && bias_valid_r) || (w_valid && w_ready && w_last)) begin
                        done_r  <= grant_r;
                        grant_r <= 2'b00;
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Output FIFO: ROM words are written two cycles after issue, popped on handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                fifo_data_r[i] <= '0;
                fifo_last_r[i] <= 1'b0;
            end
            wr_ptr_r <= 2'd0;
            rd_ptr_r <= 2'd0;
            occ_r    <= 3'd0;
        end else begin
            if (push_s) begin
                fifo_data_r[wr_ptr_r] <= rom_wdata;
                fifo_last_r[wr_ptr_r] <= iss_last_d2_r;
                wr_ptr_r              <= ptr_inc(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({push_s, pop_s})
                2'b10:   occ_r <= occ_r + 3'd1;
                2'b01:   occ_r <= occ_r - 3'd1;
                default: occ_r <= occ_r;
            endcase
        end
    end

    assign grant      = grant_r;
    assign done       = done_r;
    assign busy       = busy_r;
    assign rom_waddr  = rom_waddr_r;
    assign rom_baddr  = rom_baddr_r;
    assign bias_valid = bias_valid_r;
    assign bias_out   = bias_out_r;
    assign w_valid    = (occ_r != 3'd0);
    assign w_data     = fifo_data_r[rd_ptr_r];
    assign w_last     = w_valid && fifo_last_r[rd_ptr_r];

endmodule
